demux8_deserializer: RTL and testbench



---
 rtl/demux8_deserializer_if.sv | 34 +++
 rtl/demux8_deserializer.sv | 120 ++++++++++++
 tb/tb_demux8_deserializer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/demux8_deserializer_if.sv
// Handshake bundle for the serial-to-parallel deserializer.
// Both ports use valid/ready. A transfer happens on a rising clk edge when
// valid && ready are both high. The producer holds its data stable while valid
// is high and ready is low. in_* is driven by the serial source and out_* by
// the deserializer. The master modport is the deserializer's view of the bundle;
// the slave modport is the surrounding environment's view.
interface demux8_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  in_bit,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );

    modport slave (
        output in_bit,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/demux8_deserializer.sv
// demux8_deserializer: collects one serial bit per accepted transfer into the
// bit slot chosen by a select counter. When the frame is complete, it presents
// the word in a one-deep holding register.
// Optional macro DEMUX_PARITY_EN adds a trailing even-parity bit to each frame.
// That bit drives the parity_err output.
module demux8_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
`ifdef DEMUX_PARITY_EN
    localparam int LAST     = WIDTH,
`else
    localparam int LAST     = WIDTH - 1,
`endif
    localparam int SEL_W    = $clog2(LAST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    demux8_deserializer_if.master bus,
    output logic [SEL_W-1:0]     sel_idx
`ifdef DEMUX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             is_last;
    logic             in_ready;
    logic             accept;
    logic             consume;
    int               pos;
`ifdef DEMUX_PARITY_EN
    logic             par_q, par_d;
`endif

    // Handshake decode: only the frame-completing bit can stall, and only when
    // the holding register is full and is not being drained in this cycle.
    always_comb begin
        is_last  = (sel_q == SEL_W'(LAST));
        in_ready = !(is_last && out_valid_q && !bus.out_ready);
        accept   = bus.in_valid && in_ready && !flush;
        consume  = out_valid_q && bus.out_ready;
    end

    // Demux the incoming bit into its slot. In parity mode the parity slot maps
    // outside the data word, so the merged word then equals the assembly register.
    always_comb begin
        pos    = MSB_FIRST ? (WIDTH - 1 - int'(sel_q)) : int'(sel_q);
        merged = asm_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == pos) begin
                merged[i] = bus.in_bit;
            end
        end
    end

    // Next-state logic. Flush clears the partial word but leaves the holding
    // register alone. A completion in the same cycle as a consume keeps valid high.
    always_comb begin
        sel_d       = sel_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !consume;
`ifdef DEMUX_PARITY_EN
        par_d       = par_q;
`endif
        if (flush) begin
            sel_d = '0;
            asm_d = '0;
        end else if (accept) begin
            if (is_last) begin
                out_data_d  = merged;
                out_valid_d = 1'b1;
                sel_d       = '0;
                asm_d       = '0;
`ifdef DEMUX_PARITY_EN
                par_d       = (^asm_q) ^ bus.in_bit;
`endif
            end else begin
                asm_d = merged;
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sel_q       <= sel_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef DEMUX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign sel_idx       = sel_q;
`ifdef DEMUX_PARITY_EN
    assign parity_err    = par_q;
`endif

endmodule

// File: tb/tb_demux8_deserializer.sv
// Bench for demux8_deserializer. It runs an LSB-first instance and an
// MSB-first instance side by side from the same stimulus. Both are compared
// against a frame-level reference model built from a queue of received bits.
module tb_demux8_deserializer;
`ifdef DEMUX_PARITY_EN
    localparam int FRAME = 9;
    localparam int SEL_W = 4;
`else
    localparam int FRAME = 8;
    localparam int SEL_W = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [SEL_W-1:0] sel_l, sel_m;
`ifdef DEMUX_PARITY_EN
    logic             perr_l, perr_m;
`endif

    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit       bit_q[$];
    bit       exp_valid;
    bit [7:0] exp_l, exp_m;
    bit       exp_perr;

    demux8_deserializer_if #(.WIDTH(8)) bus_l ();
    demux8_deserializer_if #(.WIDTH(8)) bus_m ();

    demux8_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus_l),
        .sel_idx    (sel_l)
`ifdef DEMUX_PARITY_EN
        ,
        .parity_err (perr_l)
`endif
    );

    demux8_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus_m),
        .sel_idx    (sel_m)
`ifdef DEMUX_PARITY_EN
        ,
        .parity_err (perr_m)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit r, input bit f);
        bus_l.in_valid  = v;
        bus_m.in_valid  = v;
        bus_l.in_bit    = b;
        bus_m.in_bit    = b;
        bus_l.out_ready = r;
        bus_m.out_ready = r;
        flush           = f;
    endtask

    task automatic model_reset();
        bit_q.delete();
        exp_valid = 1'b0;
        exp_l     = 8'h00;
        exp_m     = 8'h00;
        exp_perr  = 1'b0;
    endtask

    task automatic check_outputs(input bit er);
        chk("l_valid", 32'(bus_l.out_valid), 32'(exp_valid));
        chk("m_valid", 32'(bus_m.out_valid), 32'(exp_valid));
        chk("l_data",  32'(bus_l.out_data),  32'(exp_l));
        chk("m_data",  32'(bus_m.out_data),  32'(exp_m));
        chk("l_sel",   32'(sel_l),           32'(bit_q.size()));
        chk("m_sel",   32'(sel_m),           32'(bit_q.size()));
        chk("l_ready", 32'(bus_l.in_ready),  32'(er));
        chk("m_ready", 32'(bus_m.in_ready),  32'(er));
`ifdef DEMUX_PARITY_EN
        chk("l_perr",  32'(perr_l),          32'(exp_perr));
        chk("m_perr",  32'(perr_m),          32'(exp_perr));
`endif
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, advance the model at posedge
    task automatic cycle(input bit v, input bit b, input bit r, input bit f);
        bit       er;
        bit [7:0] wl, wm;
        bit       p;
        @(negedge clk);
        drive(v, b, r, f);
        #1;
        er = !((bit_q.size() == FRAME - 1) && exp_valid && !r);
        check_outputs(er);
        @(posedge clk);
        if (exp_valid && r) exp_valid = 1'b0;
        if (f) begin
            bit_q.delete();
        end else if (v && er) begin
            bit_q.push_back(b);
            if (bit_q.size() == FRAME) begin
                wl = 8'h00;
                wm = 8'h00;
                p  = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    p ^= bit_q[i];
                    if (i < 8) begin
                        wl[i]     = bit_q[i];
                        wm[7 - i] = bit_q[i];
                    end
                end
                exp_l     = wl;
                exp_m     = wm;
                exp_perr  = p;
                exp_valid = 1'b1;
                bit_q.delete();
            end
        end
    endtask

    // Send a full frame in time order, starting with word[0], plus an even parity bit when enabled
    task automatic send_word(input bit [7:0] word, input bit r);
        for (int i = 0; i < 8; i++) cycle(1'b1, word[i], r, 1'b0);
`ifdef DEMUX_PARITY_EN
        cycle(1'b1, ^word, r, 1'b0);
`endif
    endtask

    initial begin
        bit [7:0] w;
        // Reset
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus_l.out_valid), 32'd0);
        chk("rst_data",  32'(bus_l.out_data),  32'd0);
        chk("rst_sel",   32'(sel_l),           32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Known stream 1,0,1,1,0,0,1,0 back to back
        send_word(8'h4D, 1'b1);
        #1;
        chk("tp1_valid",  32'(bus_l.out_valid), 32'd1);
        chk("tp1_lsb",    32'(bus_l.out_data),  32'h4D);
        chk("tp1_msb",    32'(bus_m.out_data),  32'hB2);
        chk("tp1_sel",    32'(sel_l),           32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("tp1_pulse",  32'(bus_l.out_valid), 32'd0);

        // Back-pressure: FF is held while 00 assembles, and the final bit stalls
        send_word(8'hFF, 1'b0);
        for (int i = 0; i < FRAME - 1; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            chk("bp_hold",  32'(bus_l.out_data), 32'hFF);
            chk("bp_sel",   32'(sel_l),          32'(FRAME - 1));
            chk("bp_stall", 32'(bus_l.in_ready), 32'd0);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("bp_valid", 32'(bus_l.out_valid), 32'd1);
        chk("bp_data",  32'(bus_l.out_data),  32'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Flush after 5 bits; the bit presented during the flush is dropped
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("fl_sel", 32'(sel_l), 32'd0);
        send_word(8'hA5, 1'b1);
        #1;
        chk("fl_data_l", 32'(bus_l.out_data), 32'hA5);
        chk("fl_data_m", 32'(bus_m.out_data), 32'hA5);

        // Asynchronous reset mid-word, asserted between clock edges
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(bus_l.out_valid), 32'd0);
        chk("ar_data",  32'(bus_l.out_data),  32'd0);
        chk("ar_sel",   32'(sel_l),           32'd0);
        chk("ar_sel_m", 32'(sel_m),           32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_word(8'h3C, 1'b1);
        #1;
        chk("ar_word", 32'(bus_l.out_data), 32'h3C);

`ifdef DEMUX_PARITY_EN
        // Parity: 07 has odd weight, so the correct even-parity bit is 1
        w = 8'h07;
        for (int i = 0; i < 8; i++) cycle(1'b1, w[i], 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("par_ok_data", 32'(bus_l.out_data), 32'h07);
        chk("par_ok",      32'(perr_l),         32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, w[i], 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("par_bad", 32'(perr_l), 32'd1);
`endif

        // Random traffic, mostly draining
        repeat (500) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        // Random traffic with heavy back-pressure
        repeat (300) begin
            w = 8'($urandom);
            cycle($urandom_range(0, 3) != 0, w[0],
                  $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
